// File: rtl/msk_pkg.sv
// msk_pkg: shared state type and elaboration-time helpers for the MSK modulator
package msk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
  localparam real PI = 3.14159265358979323846;
  function automatic int ph_w(int sps);
    return $clog2(4 * sps);
  endfunction
  // Rounded, saturated AMP*cos/sin of table entry idx; evaluated only at elaboration
  function automatic int rom_val(int idx, int sps, int amp, int iw, bit is_sin);
    int lim, v;
    real a, r;
    lim = amp < 2 ** (iw - 1) - 1 ? amp : 2 ** (iw - 1) - 1;
    a = 2.0 * PI * idx / (4 * sps);
    r = amp * (is_sin ? $sin(a) : $cos(a));
    v = r < 0.0 ? -$rtoi(0.5 - r) : $rtoi(r + 0.5);
    return v > lim ? lim : v < -lim ? -lim : v;
  endfunction
endpackage

// File: rtl/msk_modulator_if.sv
// msk_modulator_if: bit-stream input and I/Q sample output of the MSK modulator
interface msk_modulator_if #(parameter int IW = 16);
  logic en, bit_valid, bit_data, bit_ready;
  logic dout_valid, sym_valid, sym_bit, underrun;
  logic signed [IW-1:0] dout_i, dout_q;
  modport master (
    output en, bit_valid, bit_data,
    input bit_ready, dout_valid, dout_i, dout_q, sym_valid, sym_bit, underrun
  );
  modport slave (
    input en, bit_valid, bit_data,
    output bit_ready, dout_valid, dout_i, dout_q, sym_valid, sym_bit, underrun
  );
endinterface

// File: rtl/msk_sincos_rom.sv
// msk_sincos_rom: registered cos/sin lookup over one carrier cycle of 4*SPS phase steps
module msk_sincos_rom import msk_pkg::*; #(
  parameter int IW = 16,
  parameter int SPS = 20,
  parameter int AMP = 2 ** (IW - 1) - 1
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  input logic [ph_w(SPS)-1:0] idx,
  output logic signed [IW-1:0] cos_val,
  output logic signed [IW-1:0] sin_val
);
  logic signed [IW-1:0] cos_tbl [4*SPS];
  logic signed [IW-1:0] sin_tbl [4*SPS];
  for (genvar i = 0; i < 4 * SPS; i++) begin : g_tbl
    localparam logic signed [IW-1:0] C = IW'(rom_val(i, SPS, AMP, IW, 1'b0));
    localparam logic signed [IW-1:0] S = IW'(rom_val(i, SPS, AMP, IW, 1'b1));
    assign cos_tbl[i] = C;
    assign sin_tbl[i] = S;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cos_val <= '0;
      sin_val <= '0;
    end else begin
      cos_val <= clr ? '0 : cos_tbl[idx];
      sin_val <= clr ? '0 : sin_tbl[idx];
    end
endmodule

// File: rtl/msk_modulator.sv
// msk_modulator: continuous-phase MSK I/Q modulator fed by a valid/ready bit stream.
// Phase is an exact integer index stepping +-1 per sample; outputs lag ph by one cycle.
module msk_modulator import msk_pkg::*; #(
  parameter int IW = 16,
  parameter int SPS = 20,
  parameter int AMP = 2 ** (IW - 1) - 1
) (
  input logic clk,
  input logic rst_n,
  msk_modulator_if.slave bus
);
  localparam int PW = ph_w(SPS);
  localparam int KW = $clog2(SPS);
  localparam logic [PW-1:0] PH_MAX = PW'(4 * SPS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(SPS - 1);
  localparam logic [KW-1:0] K_MID = KW'(SPS / 2 - 1);
  state_t state, state_nx;
  logic [PW-1:0] ph, ph_nx, ph_up, ph_dn;
  logic [KW-1:0] k, k_nx;
  logic cur_bit, cur_bit_nx, live, last, xfer;
  assign last = k == K_LAST;
  assign ph_up = ph == PH_MAX ? '0 : ph + 1'b1;
  assign ph_dn = ph == '0 ? PH_MAX : ph - 1'b1;
  // live keeps ready low until the first edge after reset release
  assign bus.bit_ready = live && (state == IDLE ? bus.en : state == STALL || (last && bus.en));
  assign xfer = bus.bit_valid && bus.bit_ready;
  always_comb begin
    state_nx = state;
    ph_nx = ph;
    k_nx = k;
    cur_bit_nx = cur_bit;
    if (xfer) begin
      state_nx = RUN;
      cur_bit_nx = bus.bit_data;
      k_nx = '0;
      ph_nx = bus.bit_data ? ph_up : ph_dn;
    end else if (state == RUN && !last) begin
      k_nx = k + 1'b1;
      ph_nx = cur_bit ? ph_up : ph_dn;
    end else if (state != IDLE && !bus.en) begin
      state_nx = IDLE;
      ph_nx = '0;
      k_nx = '0;
    end else if (state == RUN) begin
      state_nx = STALL;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ph <= '0;
      k <= '0;
      cur_bit <= 1'b0;
      live <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.sym_valid <= 1'b0;
      bus.sym_bit <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      state <= state_nx;
      ph <= ph_nx;
      k <= k_nx;
      cur_bit <= cur_bit_nx;
      live <= 1'b1;
      bus.dout_valid <= state != IDLE;
      bus.sym_valid <= state == RUN && k == K_MID;
      bus.sym_bit <= state == RUN && k == K_MID && cur_bit;
      bus.underrun <= state == RUN && last && bus.en && !xfer;
    end
  msk_sincos_rom #(.IW(IW), .SPS(SPS), .AMP(AMP)) u_rom (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE),
    .idx(ph),
    .cos_val(bus.dout_i),
    .sin_val(bus.dout_q)
  );
endmodule
